cia_cycle_controller: RTL

CIA_CYCLE_CONTROLLER -- requirements
Module: cia_cycle_controller

---
 rtl/cia_cycle_controller_pkg.sv | 20 ++
 rtl/cia_cycle_controller_if.sv | 19 +
 rtl/cia_cycle_controller_e_sync.sv | 28 ++
 rtl/cia_cycle_controller.sv | 119 +++++++++++
 4 files changed

// File: rtl/cia_cycle_controller_pkg.sv
// Shared definitions for the CIA cycle controller: FSM encoding, owner
// encoding and the default timeout.
package cia_cycle_controller_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_ASSERT = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_PCI = 1'b1;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic logic is_active(input logic [2:0] st);
    return (st == ST_SYNC) || (st == ST_ASSERT) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/cia_cycle_controller_if.sv
// Requester handshake and CIA bus signals of the cycle controller.
interface cia_cycle_controller_if;
  logic cpu_req, cpu_rnw, cpu_sel;
  logic pci_req, pci_rnw, pci_sel;
  logic cpu_ack, pci_ack, cpu_err, pci_err;
  logic ciaa_csn, ciab_csn, cia_rnw, bus_oe, dlatch;

  modport master (
    output cpu_req, cpu_rnw, cpu_sel, pci_req, pci_rnw, pci_sel,
    input  cpu_ack, pci_ack, cpu_err, pci_err,
    input  ciaa_csn, ciab_csn, cia_rnw, bus_oe, dlatch
  );

  modport slave (
    input  cpu_req, cpu_rnw, cpu_sel, pci_req, pci_rnw, pci_sel,
    output cpu_ack, pci_ack, cpu_err, pci_err,
    output ciaa_csn, ciab_csn, cia_rnw, bus_oe, dlatch
  );
endinterface

// File: rtl/cia_cycle_controller_e_sync.sv
// Two-flop synchronizer for the CIA E clock with one-cycle edge pulses
// derived from the synchronized level.
module cia_e_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_e,
  output logic o_e_rise,
  output logic o_e_fall
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_e;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_e_rise = r_s2 & ~r_s3;
  assign o_e_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/cia_cycle_controller.sv
// Arbitrates CPU and PCI-bridge requests onto the two CIAs, aligning each
// access to the E clock and guarding it with a timeout.
module cia_cycle_controller
  import cia_cycle_controller_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic CLK40,
  input  logic RESETn,
  input  logic CLKCIA,
  input  logic CPU_REQ,
  input  logic CPU_RnW,
  input  logic CPU_SEL,
  input  logic PCI_REQ,
  input  logic PCI_RnW,
  input  logic PCI_SEL,
  output logic CPU_ACK,
  output logic PCI_ACK,
  output logic CPU_ERR,
  output logic PCI_ERR,
  output logic CIAA_CSn,
  output logic CIAB_CSn,
  output logic CIA_RnW,
  output logic BUS_OE,
  output logic DLATCH
);

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

  logic       w_e_rise, w_e_fall;
  logic [2:0] r_state, w_next;
  logic       r_owner, r_rnw, r_sel, r_rr_last, r_holdoff;
  logic [7:0] r_cnt;
  logic       r_csa_n, r_csb_n, r_cia_rnw, r_bus_oe;
  logic       r_cpu_ack, r_pci_ack, r_cpu_err, r_pci_err;
  logic       w_grant, w_cpu_wins, w_to, w_cs_on, w_ok_done;

  cia_e_sync u_e_sync (
    .i_clk    (CLK40),
    .i_rst_n  (RESETn),
    .i_e      (CLKCIA),
    .o_e_rise (w_e_rise),
    .o_e_fall (w_e_fall)
  );

  // The cycle after DONE is masked so a requester still holding REQ while
  // it reacts to ACK is not re-granted.
  assign w_grant    = (r_state == ST_IDLE) && !r_holdoff && (CPU_REQ || PCI_REQ);
  assign w_cpu_wins = CPU_REQ && (!PCI_REQ || (r_rr_last == OWNER_PCI));
  assign w_to       = is_active(r_state) && (r_cnt == LP_TO_LAST);
  assign w_ok_done  = (r_state == ST_HOLD) && w_e_fall && !w_to;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant) w_next = ST_SYNC;
      ST_SYNC:   if (w_to) w_next = ST_DONE; else if (w_e_fall) w_next = ST_ASSERT;
      ST_ASSERT: if (w_to) w_next = ST_DONE; else if (w_e_rise) w_next = ST_HOLD;
      ST_HOLD:   if (w_to || w_e_fall) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_cs_on = (w_next == ST_ASSERT) || (w_next == ST_HOLD);

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWNER_CPU;
      r_rnw     <= 1'b1;
      r_sel     <= 1'b0;
      r_rr_last <= OWNER_PCI;
      r_holdoff <= 1'b0;
      r_cnt     <= '0;
      r_csa_n   <= 1'b1;
      r_csb_n   <= 1'b1;
      r_cia_rnw <= 1'b1;
      r_bus_oe  <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_pci_ack <= 1'b0;
      r_cpu_err <= 1'b0;
      r_pci_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_holdoff <= (r_state == ST_DONE);
      if (w_grant) begin
        r_owner   <= w_cpu_wins ? OWNER_CPU : OWNER_PCI;
        r_rnw     <= w_cpu_wins ? CPU_RnW : PCI_RnW;
        r_sel     <= w_cpu_wins ? CPU_SEL : PCI_SEL;
        r_rr_last <= w_cpu_wins ? OWNER_CPU : OWNER_PCI;
        r_cnt     <= '0;
      end else if (is_active(r_state)) begin
        r_cnt <= r_cnt + 8'd1;
      end
      // Bus outputs are registered from the next state so they change
      // cleanly on the clock edge that enters or leaves the CS window.
      r_csa_n   <= !(w_cs_on && !r_sel);
      r_csb_n   <= !(w_cs_on && r_sel);
      r_cia_rnw <= w_cs_on ? r_rnw : 1'b1;
      r_bus_oe  <= w_cs_on && !r_rnw;
      r_cpu_ack <= w_ok_done && (r_owner == OWNER_CPU);
      r_pci_ack <= w_ok_done && (r_owner == OWNER_PCI);
      r_cpu_err <= w_to && (r_owner == OWNER_CPU);
      r_pci_err <= w_to && (r_owner == OWNER_PCI);
    end
  end

  assign CPU_ACK  = r_cpu_ack;
  assign PCI_ACK  = r_pci_ack;
  assign CPU_ERR  = r_cpu_err;
  assign PCI_ERR  = r_pci_err;
  assign CIAA_CSn = r_csa_n;
  assign CIAB_CSn = r_csb_n;
  assign CIA_RnW  = r_cia_rnw;
  assign BUS_OE   = r_bus_oe;
  assign DLATCH   = w_ok_done && r_rnw;

endmodule
